// File: rtl/keccak_pad_finalize_multi.sv
// Keccak finalize engine: XORs the domain-separation byte at pos and 0x80 at byte r-1, one lane RMW per cycle.
// Optional macro KECCAK_FIN_RANGE_CHECK_EN enables the pos < r range check and the error flag.
module keccak_pad_finalize_multi #(
    parameter int unsigned POS_W        = 32,
    parameter int unsigned LANE_W       = 64,
    parameter int unsigned DEFAULT_MODE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             mode_valid,
    input  logic [1599:0]    state_s_in,
    input  logic [POS_W-1:0] state_pos_in,
    output logic [1599:0]    state_s_out,
    output logic [POS_W-1:0] state_pos_out,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam int unsigned STATE_W = 1600;
    localparam int unsigned NBYTES  = STATE_W / 8;
    localparam int unsigned LANE_B  = LANE_W / 8;
    localparam int unsigned N_LANES = STATE_W / LANE_W;
    localparam int unsigned LIDX_W  = $clog2(N_LANES);
    localparam int unsigned BSEL_W  = (LANE_B > 1) ? $clog2(LANE_B) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD_DS,
        S_PAD_END,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [STATE_W-1:0]   work_q, work_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [7:0]           rate_q, rate_d;
    logic [7:0]           ds_q, ds_d;
    logic                 err_pend_q, err_pend_d;
    logic [STATE_W-1:0]   s_out_q, s_out_d;
    logic [POS_W-1:0]     pos_out_q, pos_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [1:0]           mode_sel;
    logic [7:0]           pos_idx;

    function automatic logic [7:0] mode_rate(input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = 8'd168;
            2'd1:    r = 8'd136;
            2'd2:    r = 8'd136;
            default: r = 8'd72;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] mode_ds(input logic [1:0] m);
        return (m < 2'd2) ? 8'h1F : 8'h06;
    endfunction

    // Read one lane, XOR val into the addressed byte, write the lane back
    function automatic logic [STATE_W-1:0] xor_byte(input logic [STATE_W-1:0] s,
                                                    input logic [7:0]         idx,
                                                    input logic [7:0]         val);
        logic [STATE_W-1:0] res;
        logic [LANE_W-1:0]  lane;
        logic [LIDX_W-1:0]  li;
        logic [BSEL_W-1:0]  bs;
        li   = LIDX_W'(idx / 8'(LANE_B));
        bs   = BSEL_W'(idx % 8'(LANE_B));
        res  = s;
        lane = s[32'(li) * LANE_W +: LANE_W];
        lane[32'(bs) * 8 +: 8] = lane[32'(bs) * 8 +: 8] ^ val;
        res[32'(li) * LANE_W +: LANE_W] = lane;
        return res;
    endfunction

    assign mode_sel = mode_valid ? mode : 2'(DEFAULT_MODE);
    assign pos_idx  = pos_q[7:0];

`ifndef KECCAK_FIN_RANGE_CHECK_EN
    logic unused_pos_hi;
    assign unused_pos_hi = ^pos_q[POS_W-1:8];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            pos_q      <= '0;
            rate_q     <= '0;
            ds_q       <= '0;
            err_pend_q <= 1'b0;
            s_out_q    <= '0;
            pos_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            pos_q      <= pos_d;
            rate_q     <= rate_d;
            ds_q       <= ds_d;
            err_pend_q <= err_pend_d;
            s_out_q    <= s_out_d;
            pos_out_q  <= pos_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        pos_d      = pos_q;
        rate_d     = rate_q;
        ds_d       = ds_q;
        err_pend_d = err_pend_q;
        s_out_d    = s_out_q;
        pos_out_d  = pos_out_q;
        error_d    = error_q;
        done_d     = 1'b0;

        case (state_q)
            // A start coinciding with the done pulse is dropped
            S_IDLE: begin
                if (start && !done_q) begin
                    work_d     = state_s_in;
                    pos_d      = state_pos_in;
                    rate_d     = mode_rate(mode_sel);
                    ds_d       = mode_ds(mode_sel);
                    err_pend_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef KECCAK_FIN_RANGE_CHECK_EN
                if (pos_q >= POS_W'(rate_q)) begin
                    err_pend_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d    = S_PAD_DS;
                end
`else
                state_d = S_PAD_DS;
`endif
            end
            S_PAD_DS: begin
                if (pos_idx < 8'(NBYTES)) begin
                    work_d = xor_byte(work_q, pos_idx, ds_q);
                end
                state_d = S_PAD_END;
            end
            S_PAD_END: begin
                work_d  = xor_byte(work_q, rate_q - 8'd1, 8'h80);
                state_d = S_DONE;
            end
            S_DONE: begin
                s_out_d   = work_q;
                pos_out_d = POS_W'(rate_q);
                error_d   = err_pend_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign state_s_out   = s_out_q;
    assign state_pos_out = pos_out_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_keccak_pad_finalize_multi.sv
// Self-checking bench for keccak_pad_finalize_multi: byte-array padding model, job queue and per-cycle compare.
module tb_keccak_pad_finalize_multi;
    localparam int unsigned DEF_MODE = 0;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          mode_valid = 1'b0;
    logic [1599:0] s_in = '0;
    logic [31:0]   pos_in = '0;
    logic [1599:0] s_out;
    logic [31:0]   pos_out;
    logic          busy, done, error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int            start_cyc;
        int            due;
        logic [1599:0] s;
        logic [31:0]   r;
        logic          err;
    } job_t;

    job_t          q[$];
    logic [1599:0] held_s = '0;
    logic [31:0]   held_r = '0;
    logic          held_err = 1'b0;
    logic          exp_done, exp_busy;

    keccak_pad_finalize_multi #(
        .POS_W(32), .LANE_W(64), .DEFAULT_MODE(DEF_MODE)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .mode_valid(mode_valid),
        .state_s_in(s_in), .state_pos_in(pos_in), .state_s_out(s_out), .state_pos_out(pos_out),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_state(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            errors++;
            k = 0;
            for (int i = 0; i < 200; i++) begin
                if (act[8*i +: 8] !== exp[8*i +: 8]) begin
                    k = i;
                    break;
                end
            end
            $display("FAIL %s: byte %0d got %02h expected %02h (cycle %0d)",
                     name, k, act[8*k +: 8], exp[8*k +: 8], cyc);
        end
    endtask

    // Padding rules on a plain byte view of the state
    function automatic job_t model(input logic [1599:0] s, input logic [31:0] pos,
                                   input logic [1:0] m, input logic mv, input int n);
        job_t          j;
        logic [1599:0] t;
        logic [1:0]    me;
        int            r;
        int            p;
        logic [7:0]    ds;
        me = mv ? m : 2'(DEF_MODE);
        case (me)
            2'd0:    r = 168;
            2'd1:    r = 136;
            2'd2:    r = 136;
            default: r = 72;
        endcase
        ds = (me < 2'd2) ? 8'h1F : 8'h06;
        t = s;
        j.start_cyc = n;
        j.due = n + 4;
        j.r = 32'(r);
        j.err = 1'b0;
`ifdef KECCAK_FIN_RANGE_CHECK_EN
        if (pos >= 32'(r)) begin
            j.err = 1'b1;
            j.due = n + 2;
            j.s = t;
            return j;
        end
        p = int'(pos);
`else
        p = int'(pos[7:0]);
`endif
        if (p < 200) t[8*p +: 8] = t[8*p +: 8] ^ ds;
        t[8*(r-1) +: 8] = t[8*(r-1) +: 8] ^ 8'h80;
        j.s = t;
        return j;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // Per-cycle compare against the job queue and the last completed job
    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_err", 32'(error), 32'd0);
            chk("rst_pos", pos_out, 32'd0);
            chk_state("rst_state", s_out, '0);
        end else begin
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            exp_busy = (q.size() > 0) && (cyc >= q[0].start_cyc) && (cyc < q[0].due);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_done) begin
                held_s = q[0].s;
                held_r = q[0].r;
                held_err = q[0].err;
                void'(q.pop_front());
            end
            chk_state("state_out", s_out, held_s);
            chk("pos_out", pos_out, held_r);
            chk("error", 32'(error), 32'(held_err));
        end
    end

    // Caller sits 2ns after a rising edge; start is sampled at the next edge
    task automatic drive(input logic [1599:0] s, input logic [31:0] p, input logic [1:0] m,
                         input logic mv, input bit accept);
        s_in = s;
        pos_in = p;
        mode = m;
        mode_valid = mv;
        start = 1'b1;
        if (accept) q.push_back(model(s, p, m, mv, cyc + 1));
        @(posedge clock);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(posedge clock);
            #2;
            s_in = rand_state();
            pos_in = $urandom;
            mode = 2'($urandom_range(0, 3));
            mode_valid = 1'($urandom_range(0, 1));
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles (cycle %0d)", cyc);
            q.delete();
        end
    endtask

    initial begin
        logic [1599:0] e, s, ff;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #2;

        // SHAKE128, zero state, pos 0
        drive('0, 32'd0, 2'd0, 1'b1, 1'b1);
        wait_idle();
        e = '0;
        e[7:0] = 8'h1F;
        e[167*8 +: 8] = 8'h80;
        chk_state("t1_state", s_out, e);
        chk("t1_pos", pos_out, 32'd168);
        chk("t1_err", 32'(error), 32'd0);

        // SHA3-512, all-ones state, pos 10
        ff = '1;
        drive(ff, 32'd10, 2'd3, 1'b1, 1'b1);
        wait_idle();
        e = ff;
        e[10*8 +: 8] = 8'hF9;
        e[71*8 +: 8] = 8'h7F;
        chk_state("t2_state", s_out, e);
        chk("t2_pos", pos_out, 32'd72);

        // DS and pad on the same byte
        s = rand_state();
        drive(s, 32'd135, 2'd1, 1'b1, 1'b1);
        wait_idle();
        chk("t3_shake_b135", 32'(s_out[135*8 +: 8]), 32'(s[135*8 +: 8] ^ 8'h9F));
        drive(s, 32'd135, 2'd2, 1'b1, 1'b1);
        wait_idle();
        chk("t3_sha3_b135", 32'(s_out[135*8 +: 8]), 32'(s[135*8 +: 8] ^ 8'h86));

        // pos == r
        drive(s, 32'd168, 2'd0, 1'b1, 1'b1);
        wait_idle();
        chk("t4_pos", pos_out, 32'd168);
`ifdef KECCAK_FIN_RANGE_CHECK_EN
        chk("t4_err", 32'(error), 32'd1);
        chk_state("t4_state", s_out, s);
`else
        chk("t4_err", 32'(error), 32'd0);
        chk("t4_b168", 32'(s_out[168*8 +: 8]), 32'(s[168*8 +: 8] ^ 8'h1F));
        chk("t4_b167", 32'(s_out[167*8 +: 8]), 32'(s[167*8 +: 8] ^ 8'h80));
`endif

        // Starts during the job and in the done cycle are dropped; the next one is taken
        drive(rand_state(), 32'd5, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(rand_state(), 32'($urandom_range(0, 199)), 2'd1, 1'b1, 1'b0);
        drive(rand_state(), 32'd20, 2'd3, 1'b1, 1'b1);
        wait_idle();

        // Reset while in PAD_END aborts the job
        drive(rand_state(), 32'd3, 2'd1, 1'b1, 1'b1);
        @(posedge clock);
        #2;
        @(posedge clock);
        #2;
        reset = 1'b0;
        q.delete();
        held_s = '0;
        held_r = '0;
        held_err = 1'b0;
        #1;
        chk_state("t6_rst_state", s_out, '0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_pos", pos_out, 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        repeat (6) begin
            @(posedge clock);
            #2;
        end
        s = rand_state();
        drive(s, 32'd7, 2'd3, 1'b0, 1'b1);
        wait_idle();
        chk("t6_default_pos", pos_out, 32'd168);
        chk("t6_default_b7", 32'(s_out[7*8 +: 8]), 32'(s[7*8 +: 8] ^ 8'h1F));

        // Randomized jobs with mixed position ranges and idle gaps
        for (int n = 0; n < 150; n++) begin
            logic [31:0] p;
            case ($urandom_range(0, 3))
                0:       p = 32'($urandom_range(0, 199));
                1:       p = $urandom;
                2:       p = 32'($urandom_range(0, 71));
                default: p = 32'($urandom_range(200, 1023));
            endcase
            drive(rand_state(), p, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            wait_idle();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #2;
            end
        end

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
